rpsc_interlock_seq: RTL and testbench
=====================================

# rpsc_interlock_seq

Parametrised, multi-channel power-supply interlock sequencer for the RPSC cards. It generalises the fixed per-card alarm OR, PS-active qualification and hard-coded shift-register timers into NCH cascaded channels. Each channel has its own maskable alarm vector, a programmable settle counter, undervoltage supervision, a latched fault with cause code, and operator acknowledge. Channel k may only power up while channel k-1 is OK, the same way the grid channel gates the anode channel. It sits between the card input buffers and the front-panel/status outputs.

## Interface
- NCH, 2: number of cascaded channels (≥1)
- NALM, 8: alarm inputs per channel (≥1)
- SETTLE_CYC, 128: cycles a channel must stay active and permitted before OK (≥1)
- CW, $clog2(SETTLE_CYC+1): settle counter width (derived, not overridden)

- clk, in, 1: system clock, all state on rising edge
- reset, in, 1: synchronous, active-low reset
- alarm, in, NCH*NALM: alarm inputs; channel k uses bits [k*NALM +: NALM], 1 = alarm
- alarm_mask, in, NCH*NALM: 1 = ignore the corresponding alarm bit
- ps_act, in, NCH: supply-active request/feedback per channel
- u_low, in, NCH: undervoltage flag, 1 = voltage low
- ack, in, 1: fault acknowledge, level-sampled
- permit, out, NCH: combinational ON permission per channel
- ok, out, NCH: registered, channel in OK
- fault, out, NCH: registered, channel in FAULT
- cause, out, 2*NCH: registered per-channel fault cause; 0 none, 1 alarm, 2 upstream lost, 3 undervoltage
- first_ch, out, max(1,$clog2(NCH)): first channel to fault since last clear
- first_vld, out, 1: first_ch valid

## Operation
- alarm_any[k] = |(alarm[k] & ~alarm_mask[k]).
- up_ok[k] = 1 for k=0; otherwise ok[k-1] (registered).
- permit[k] = ~alarm_any[k] & up_ok[k] & ~fault[k].
- Per-channel FSM, states IDLE, SETTLE, OK, FAULT:
  - IDLE: ps_act & permit → SETTLE, cnt←0. ps_act with no permit stays in IDLE. No fault is raised without activity.
  - SETTLE: ~ps_act → IDLE. Else ~permit → FAULT. Else cnt==SETTLE_CYC-1 → OK. Else cnt++.
  - OK: ~ps_act → IDLE. Else ~permit or u_low → FAULT.
  - FAULT: ack & ~ps_act & ~alarm_any → IDLE, cause←0. Otherwise hold.
- u_low is ignored in IDLE and SETTLE.
- Cause priority on the fault-entry cycle: alarm(1) > upstream lost(2) > undervoltage(3). Cause is held until exit from FAULT.
- Cascade: a fault in channel k drops ok[k]. Channel k+1 then faults with cause 2 one cycle later, and so on down the chain.
- first_vld/first_ch: set on the first edge at which any channel enters FAULT while first_vld=0. If several channels enter on that edge, the lowest index wins. Cleared when ack=1 and no channel is in FAULT after the edge.
- ps_act deassert in any non-FAULT state is a normal shutdown. It is not a fault.

## Timing
- Reset (reset=0 at an edge): all channels IDLE, cnt=0; ok=0, fault=0, cause=0, first_vld=0, first_ch=0. permit then follows its equation, with fault=0.
- reset overrides all other inputs, including mid-SETTLE and during FAULT.
- If ps_act and permit are sampled at edge e0, SETTLE is entered after e0 and ok rises after edge e0+SETTLE_CYC. With SETTLE_CYC=1, ok rises after e0+1.
- Any disqualification in SETTLE/OK: fault rises and ok falls after the same sampling edge, a latency of 1.
- permit responds combinationally to alarm/mask in the same cycle, and to fault/up_ok one cycle after their edge.
- ack is honoured on any edge where the exit conditions hold. Holding ack high does not block new faults; re-fault behaviour follows the FSM.

## Test plan
(NCH=2, NALM=4, SETTLE_CYC=8)
- Reset: hold reset=0 for 2 edges with alarm=8'hFF, ps_act=2'b11 → ok=0, fault=0, cause=0, first_vld=0. With alarms then cleared → permit=2'b01.
- Power-up: ps_act[0]=1 at e0 → ok[0] after e0+8. ps_act[1]=1 at e9 → ok[1] after e17. ok[1] stays 0 while ok[0]=0.
- Cascade: with both OK, alarm[2]=1 → next edge fault[0]=1, cause[0]=1. The following edge fault[1]=1, cause[1]=2, first_ch=0, first_vld=1.
- Masking/undervoltage: alarm_mask[2]=1 with alarm[2]=1 → no fault. u_low[1]=1 during SETTLE → ignored. u_low[1]=1 in OK → fault[1], cause[1]=3.
- Simultaneous: alarm[0] and u_low[0] in the same OK cycle → cause[0]=1. Both channels faulting on the same edge → first_ch=0.
- Clear/abort: ack=1 with ps_act[0]=1 → stays FAULT. Drop ps_act and alarms → IDLE after 1 edge, cause=0, first_vld=0. ps_act drop mid-SETTLE at cnt=5 → IDLE with no fault.

Source files
------------

// File: rtl/rpsc_interlock_seq.sv
// Cascaded power-supply interlock sequencer: per-channel alarm/settle/undervoltage
// supervision with latched fault causes and first-fault capture across the chain.
module rpsc_interlock_seq #(
  parameter  int NCH        = 2,
  parameter  int NALM       = 8,
  parameter  int SETTLE_CYC = 128,
  localparam int CW         = $clog2(SETTLE_CYC + 1),
  localparam int FW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH*NALM-1:0] alarm,
  input  logic [NCH*NALM-1:0] alarm_mask,
  input  logic [NCH-1:0]      ps_act,
  input  logic [NCH-1:0]      u_low,
  input  logic                ack,
  output logic [NCH-1:0]      permit,
  output logic [NCH-1:0]      ok,
  output logic [NCH-1:0]      fault,
  output logic [2*NCH-1:0]    cause,
  output logic [FW-1:0]       first_ch,
  output logic                first_vld
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OK     = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_ALARM = 2'd1;
  localparam logic [1:0] CAUSE_UP    = 2'd2;
  localparam logic [1:0] CAUSE_UV    = 2'd3;

  logic [NCH-1:0] w_alarm_any;
  logic [NCH-1:0] w_up_ok;
  logic [NCH-1:0] w_permit;
  logic [NCH-1:0] w_ok;
  logic [NCH-1:0] w_fault;
  logic [NCH-1:0] w_enter_fault;
  logic [NCH-1:0] w_fault_next;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      state_t          r_state;
      state_t          w_state_next;
      logic [CW-1:0]   r_cnt;
      logic [CW-1:0]   w_cnt_next;
      logic [1:0]      r_cause;
      logic [1:0]      w_cause_next;
      logic [1:0]      w_cause_dq;
      logic            r_ok;
      logic            r_fault;

      assign w_alarm_any[gi] = |(alarm[gi*NALM +: NALM] & ~alarm_mask[gi*NALM +: NALM]);

      // Channel 0 heads the chain; every other channel is gated by its upstream OK.
      if (gi == 0) begin : g_head
        assign w_up_ok[gi] = 1'b1;
      end else begin : g_tail
        assign w_up_ok[gi] = w_ok[gi-1];
      end

      assign w_permit[gi] = ~w_alarm_any[gi] & w_up_ok[gi] & ~r_fault;

      // Disqualification cause, highest priority first.
      assign w_cause_dq = w_alarm_any[gi] ? CAUSE_ALARM :
                          (!w_up_ok[gi])  ? CAUSE_UP    : CAUSE_UV;

      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cause_next = r_cause;
        case (r_state)
          ST_IDLE: begin
            if (ps_act[gi] && w_permit[gi]) begin
              w_state_next = ST_SETTLE;
              w_cnt_next   = '0;
            end
          end
          ST_SETTLE: begin
            if (!ps_act[gi]) begin
              w_state_next = ST_IDLE;
            end else if (!w_permit[gi]) begin
              w_state_next = ST_FAULT;
              w_cause_next = w_cause_dq;
            end else if (r_cnt == CW'(SETTLE_CYC - 1)) begin
              w_state_next = ST_OK;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
          ST_OK: begin
            if (!ps_act[gi]) begin
              w_state_next = ST_IDLE;
            end else if (!w_permit[gi] || u_low[gi]) begin
              w_state_next = ST_FAULT;
              w_cause_next = w_cause_dq;
            end
          end
          ST_FAULT: begin
            if (ack && !ps_act[gi] && !w_alarm_any[gi]) begin
              w_state_next = ST_IDLE;
              w_cause_next = CAUSE_NONE;
            end
          end
          default: begin
            w_state_next = ST_IDLE;
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_cause <= CAUSE_NONE;
          r_ok    <= 1'b0;
          r_fault <= 1'b0;
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
          r_cause <= w_cause_next;
          r_ok    <= (w_state_next == ST_OK);
          r_fault <= (w_state_next == ST_FAULT);
        end
      end

      assign w_ok[gi]          = r_ok;
      assign w_fault[gi]       = r_fault;
      assign w_fault_next[gi]  = (w_state_next == ST_FAULT);
      assign w_enter_fault[gi] = (w_state_next == ST_FAULT) && (r_state != ST_FAULT);
      assign cause[2*gi +: 2]  = r_cause;
    end
  endgenerate

  assign permit = w_permit;
  assign ok     = w_ok;
  assign fault  = w_fault;

  // First-fault capture: lowest-index channel wins on a simultaneous entry.
  logic [FW-1:0] w_first_idx;
  logic          r_first_vld;
  logic [FW-1:0] r_first_ch;

  always_comb begin
    w_first_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_enter_fault[i]) begin
        w_first_idx = FW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_first_vld <= 1'b0;
      r_first_ch  <= '0;
    end else if (!r_first_vld && (|w_enter_fault)) begin
      r_first_vld <= 1'b1;
      r_first_ch  <= w_first_idx;
    end else if (ack && !(|w_fault_next)) begin
      r_first_vld <= 1'b0;
      r_first_ch  <= '0;
    end
  end

  assign first_vld = r_first_vld;
  assign first_ch  = r_first_ch;

endmodule

// File: tb/tb_rpsc_interlock_seq.sv
// Self-checking bench for rpsc_interlock_seq: directed scenarios plus randomized
// traffic compared against a rule-level model of the interlock chain.
module tb_rpsc_interlock_seq;
  localparam int NCH  = 2;
  localparam int NALM = 4;
  localparam int SC   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] alarm = '0;
  logic [7:0] alarm_mask = '0;
  logic [1:0] ps_act = '0;
  logic [1:0] u_low = '0;
  logic       ack = 1'b0;
  logic [1:0] permit;
  logic [1:0] ok;
  logic [1:0] fault;
  logic [3:0] cause;
  logic [0:0] first_ch;
  logic       first_vld;

  rpsc_interlock_seq #(.NCH(NCH), .NALM(NALM), .SETTLE_CYC(SC)) dut (
    .clk(clk), .reset(reset), .alarm(alarm), .alarm_mask(alarm_mask),
    .ps_act(ps_act), .u_low(u_low), .ack(ack), .permit(permit), .ok(ok),
    .fault(fault), .cause(cause), .first_ch(first_ch), .first_vld(first_vld)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: per channel whether it is powered-and-OK, faulted, or counting
  // elapsed settle cycles, plus the first-fault record.
  bit m_ok[NCH];
  bit m_fault[NCH];
  bit m_settling[NCH];
  int m_elapsed[NCH];
  int m_cause[NCH];
  bit m_fv;
  int m_fc;

  function automatic bit m_aa(int k);
    return |(alarm[k*NALM +: NALM] & ~alarm_mask[k*NALM +: NALM]);
  endfunction

  function automatic logic [1:0] exp_permit();
    logic [1:0] p;
    for (int k = 0; k < NCH; k++)
      p[k] = !m_aa(k) && (k == 0 || m_ok[k-1]) && !m_fault[k];
    return p;
  endfunction

  function automatic logic [1:0] exp_ok();
    logic [1:0] v;
    for (int k = 0; k < NCH; k++) v[k] = m_ok[k];
    return v;
  endfunction

  function automatic logic [1:0] exp_fault();
    logic [1:0] v;
    for (int k = 0; k < NCH; k++) v[k] = m_fault[k];
    return v;
  endfunction

  function automatic logic [3:0] exp_cause();
    logic [3:0] v;
    for (int k = 0; k < NCH; k++) v[2*k +: 2] = 2'(m_cause[k]);
    return v;
  endfunction

  task automatic model_edge();
    bit n_ok[NCH], n_fault[NCH], n_set[NCH];
    int n_el[NCH], n_cause[NCH];
    int first;
    bit any_f, aa, up, pm;
    if (!reset) begin
      for (int k = 0; k < NCH; k++) begin
        m_ok[k] = 0; m_fault[k] = 0; m_settling[k] = 0; m_elapsed[k] = 0; m_cause[k] = 0;
      end
      m_fv = 0; m_fc = 0;
      return;
    end
    n_ok = m_ok; n_fault = m_fault; n_set = m_settling; n_el = m_elapsed; n_cause = m_cause;
    for (int k = 0; k < NCH; k++) begin
      aa = m_aa(k);
      up = (k == 0) ? 1'b1 : m_ok[k-1];
      pm = !aa && up && !m_fault[k];
      if (m_fault[k]) begin
        if (ack && !ps_act[k] && !aa) begin n_fault[k] = 0; n_cause[k] = 0; end
      end else if (!ps_act[k]) begin
        n_ok[k] = 0; n_set[k] = 0;
      end else if (m_ok[k]) begin
        if (!pm || u_low[k]) begin
          n_ok[k] = 0; n_fault[k] = 1; n_cause[k] = aa ? 1 : (!up ? 2 : 3);
        end
      end else if (m_settling[k]) begin
        if (!pm) begin
          n_set[k] = 0; n_fault[k] = 1; n_cause[k] = aa ? 1 : (!up ? 2 : 3);
        end else begin
          n_el[k] = m_elapsed[k] + 1;
          if (n_el[k] == SC) begin n_set[k] = 0; n_ok[k] = 1; end
        end
      end else if (pm) begin
        n_set[k] = 1; n_el[k] = 0;
      end
    end
    first = -1; any_f = 0;
    for (int k = 0; k < NCH; k++) begin
      if (n_fault[k] && !m_fault[k] && first < 0) first = k;
      any_f |= n_fault[k];
    end
    if (!m_fv && first >= 0) begin m_fv = 1; m_fc = first; end
    else if (ack && !any_f) begin m_fv = 0; m_fc = 0; end
    m_ok = n_ok; m_fault = n_fault; m_settling = n_set; m_elapsed = n_el; m_cause = n_cause;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 0; alarm = 8'hFF; ps_act = 2'b11;
    tick(); tick();
    checks++; if (ok !== 2'b00) begin failures++; $display("FAIL reset_ok got=%b exp=00", ok); end
    checks++; if (fault !== 2'b00) begin failures++; $display("FAIL reset_fault got=%b exp=00", fault); end
    checks++; if (cause !== 4'h0) begin failures++; $display("FAIL reset_cause got=%h exp=0", cause); end
    checks++; if (first_vld !== 1'b0) begin failures++; $display("FAIL reset_first_vld got=%b exp=0", first_vld); end
    checks++; if (first_ch !== 1'b0) begin failures++; $display("FAIL reset_first_ch got=%b exp=0", first_ch); end
    alarm = 8'h00; #1;
    checks++; if (permit !== 2'b01) begin failures++; $display("FAIL reset_permit got=%b exp=01", permit); end
    reset = 1; ps_act = 2'b00;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_powerup();
    logic [1:0] e;
    ps_act = 2'b11;
    for (int i = 0; i <= 17; i++) begin
      tick();
      e = {(i >= 17) ? 1'b1 : 1'b0, (i >= 8) ? 1'b1 : 1'b0};
      checks++; if (ok !== e) begin failures++; $display("FAIL powerup_ok edge=%0d got=%b exp=%b", i, ok, e); end
    end
    checks++; if (fault !== 2'b00) begin failures++; $display("FAIL powerup_fault got=%b exp=00", fault); end
    $display("test_powerup done ok=%b", ok);
  endtask

  task automatic test_cascade();
    alarm = 8'h04;
    tick();
    checks++; if (fault !== 2'b01) begin failures++; $display("FAIL casc_fault0 got=%b exp=01", fault); end
    checks++; if (cause !== 4'b0001) begin failures++; $display("FAIL casc_cause0 got=%b exp=0001", cause); end
    checks++; if (ok !== 2'b10) begin failures++; $display("FAIL casc_ok0 got=%b exp=10", ok); end
    tick();
    checks++; if (fault !== 2'b11) begin failures++; $display("FAIL casc_fault1 got=%b exp=11", fault); end
    checks++; if (cause !== 4'b1001) begin failures++; $display("FAIL casc_cause1 got=%b exp=1001", cause); end
    checks++; if (first_vld !== 1'b1 || first_ch !== 1'b0) begin
      failures++; $display("FAIL casc_first got=%b/%b exp=1/0", first_vld, first_ch); end
    alarm = 8'h00; ps_act = 2'b00; ack = 1;
    tick();
    checks++; if (fault !== 2'b00 || cause !== 4'h0 || first_vld !== 1'b0) begin
      failures++; $display("FAIL casc_clear got=%b/%h/%b exp=00/0/0", fault, cause, first_vld); end
    ack = 0;
    $display("test_cascade done");
  endtask

  task automatic test_mask_uv();
    ps_act = 2'b11;
    for (int i = 0; i < 18; i++) tick();
    checks++; if (ok !== 2'b11) begin failures++; $display("FAIL mask_pre_ok got=%b exp=11", ok); end
    alarm_mask = 8'h04; alarm = 8'h04;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (fault !== 2'b00 || ok !== 2'b11 || permit !== 2'b11) begin
      failures++; $display("FAIL mask_nofault got=%b/%b/%b exp=00/11/11", fault, ok, permit); end
    alarm = 8'h00; alarm_mask = 8'h00;
    ps_act = 2'b01;
    tick();
    ps_act = 2'b11; u_low = 2'b10;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (fault !== 2'b00 || ok !== 2'b01) begin
      failures++; $display("FAIL uv_settle got=%b/%b exp=00/01", fault, ok); end
    tick();
    checks++; if (fault !== 2'b00 || ok !== 2'b11) begin
      failures++; $display("FAIL uv_reach_ok got=%b/%b exp=00/11", fault, ok); end
    tick();
    checks++; if (fault !== 2'b10 || cause[3:2] !== 2'd3 || ok !== 2'b01) begin
      failures++; $display("FAIL uv_fault got=%b/%0d/%b exp=10/3/01", fault, cause[3:2], ok); end
    checks++; if (first_vld !== 1'b1 || first_ch !== 1'b1) begin
      failures++; $display("FAIL uv_first got=%b/%b exp=1/1", first_vld, first_ch); end
    ack = 1; u_low = 2'b00; ps_act = 2'b01;
    tick();
    checks++; if (fault !== 2'b00 || first_vld !== 1'b0) begin
      failures++; $display("FAIL uv_clear got=%b/%b exp=00/0", fault, first_vld); end
    ack = 0;
    $display("test_mask_uv done");
  endtask

  task automatic test_simultaneous();
    ps_act = 2'b11;
    for (int i = 0; i < 9; i++) tick();
    checks++; if (ok !== 2'b11) begin failures++; $display("FAIL sim_pre_ok got=%b exp=11", ok); end
    alarm = 8'h01; u_low = 2'b01;
    tick();
    checks++; if (fault !== 2'b01 || cause[1:0] !== 2'd1) begin
      failures++; $display("FAIL sim_cause_prio got=%b/%0d exp=01/1", fault, cause[1:0]); end
    ps_act = 2'b00; alarm = 8'h00; u_low = 2'b00; ack = 1;
    tick();
    ack = 0; ps_act = 2'b11;
    for (int i = 0; i < 18; i++) tick();
    checks++; if (ok !== 2'b11) begin failures++; $display("FAIL sim_repower got=%b exp=11", ok); end
    alarm = 8'h11;
    tick();
    checks++; if (fault !== 2'b11 || cause !== 4'b0101) begin
      failures++; $display("FAIL sim_both got=%b/%b exp=11/0101", fault, cause); end
    checks++; if (first_vld !== 1'b1 || first_ch !== 1'b0) begin
      failures++; $display("FAIL sim_first got=%b/%b exp=1/0", first_vld, first_ch); end
    $display("test_simultaneous done");
  endtask

  task automatic test_clear_abort();
    ack = 1; alarm = 8'h00; ps_act = 2'b11;
    tick();
    checks++; if (fault !== 2'b11) begin failures++; $display("FAIL clr_hold got=%b exp=11", fault); end
    ps_act = 2'b00;
    tick();
    checks++; if (fault !== 2'b00 || cause !== 4'h0 || first_vld !== 1'b0) begin
      failures++; $display("FAIL clr_exit got=%b/%h/%b exp=00/0/0", fault, cause, first_vld); end
    ack = 0; ps_act = 2'b01;
    for (int i = 0; i < 6; i++) tick();
    ps_act = 2'b00;
    tick();
    checks++; if (ok !== 2'b00 || fault !== 2'b00) begin
      failures++; $display("FAIL abort got=%b/%b exp=00/00", ok, fault); end
    ps_act = 2'b01;
    for (int i = 0; i < 8; i++) tick();
    checks++; if (ok[0] !== 1'b0) begin failures++; $display("FAIL abort_early got=%b exp=0", ok[0]); end
    tick();
    checks++; if (ok[0] !== 1'b1) begin failures++; $display("FAIL abort_restart got=%b exp=1", ok[0]); end
    ps_act = 2'b00;
    tick();
    $display("test_clear_abort done");
  endtask

  task automatic test_random();
    logic [1:0] ps_st;
    int nfail0;
    nfail0 = failures;
    reset = 0; tick(); reset = 1;
    ps_st = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 499) != 0);
      for (int b = 0; b < 8; b++) begin
        alarm[b] = ($urandom_range(0, 199) == 0);
        alarm_mask[b] = ($urandom_range(0, 3) == 0);
      end
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 59) == 0) ps_st[k] = ~ps_st[k];
        u_low[k] = ($urandom_range(0, 79) == 0);
      end
      ps_act = ps_st;
      ack = ($urandom_range(0, 5) == 0);
      #1;
      checks++; if (permit !== exp_permit()) begin
        failures++; $display("FAIL rnd_permit cyc=%0d got=%b exp=%b", n, permit, exp_permit()); end
      tick();
      checks++; if (ok !== exp_ok()) begin
        failures++; $display("FAIL rnd_ok cyc=%0d got=%b exp=%b", n, ok, exp_ok()); end
      checks++; if (fault !== exp_fault()) begin
        failures++; $display("FAIL rnd_fault cyc=%0d got=%b exp=%b", n, fault, exp_fault()); end
      checks++; if (cause !== exp_cause()) begin
        failures++; $display("FAIL rnd_cause cyc=%0d got=%b exp=%b", n, cause, exp_cause()); end
      checks++; if (first_vld !== m_fv || first_ch !== 1'(m_fc)) begin
        failures++; $display("FAIL rnd_first cyc=%0d got=%b/%b exp=%b/%0d", n, first_vld, first_ch, m_fv, m_fc); end
    end
    $display("test_random done new_failures=%0d", failures - nfail0);
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_cascade();
    test_mask_uv();
    test_simultaneous();
    test_clear_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
